// File: rtl/arm_servo_pkg.sv
// Shared constants and enums for the three-axis servo arm controller.
// Pulse widths are in clk ticks; PW_W must be wide enough for PW_MAX.
package arm_servo_pkg;

  localparam int PW_W = 17;

  localparam int DEF_FRAME_TICKS   = 1_000_000;
  localparam int DEF_PW_MIN        = 50_000;
  localparam int DEF_PW_MAX        = 100_000;
  localparam int DEF_PW_CENTER     = 75_000;
  localparam int DEF_STEP          = 500;
  localparam int DEF_SLEW          = 250;
  localparam int DEF_HOLD_FRAMES   = 25;
  localparam int DEF_REPEAT_FRAMES = 10;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } btn_state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

endpackage

// File: rtl/servo_axis_ramp.sv
// One servo axis: saturating target update on button events,
// home override, and a slew-limited ramp of the output once per frame.
module servo_axis_ramp
  import arm_servo_pkg::*;
#(
  parameter int PW_MIN    = DEF_PW_MIN,
  parameter int PW_MAX    = DEF_PW_MAX,
  parameter int PW_CENTER = DEF_PW_CENTER,
  parameter int STEP      = DEF_STEP,
  parameter int SLEW      = DEF_SLEW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            ev,
  input  dir_e            dir,
  input  logic            axis_en,
  input  logic            home,
  output logic [PW_W-1:0] pw,
  output logic            busy
);

  localparam int W1 = PW_W + 1;

  localparam logic [W1-1:0] MIN_W  = W1'(PW_MIN);
  localparam logic [W1-1:0] MAX_W  = W1'(PW_MAX);
  localparam logic [W1-1:0] STEP_W = W1'(STEP);
  localparam logic [W1-1:0] SLEW_W = W1'(SLEW);

  localparam logic [PW_W-1:0] MIN_N = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] MAX_N = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] CTR_N = PW_W'(PW_CENTER);

  logic [PW_W-1:0] tgt_q, tgt_d;
  logic [PW_W-1:0] cur_q, cur_d;
  logic            busy_q, busy_d;

  logic [W1-1:0] tgt_w, cur_w, sum_w, dif_w;

  always_comb begin
    tgt_w  = {1'b0, tgt_q};
    cur_w  = {1'b0, cur_q};
    sum_w  = '0;
    dif_w  = '0;
    tgt_d  = tgt_q;
    cur_d  = cur_q;
    busy_d = busy_q;

    // home beats a same-cycle event
    if (home) begin
      tgt_d = CTR_N;
    end else if (ev && axis_en) begin
      if (dir == DIR_UP) begin
        sum_w = tgt_w + STEP_W;
        tgt_d = (sum_w > MAX_W) ? MAX_N : sum_w[PW_W-1:0];
      end else begin
        sum_w = tgt_w - STEP_W;
        tgt_d = (tgt_w < MIN_W + STEP_W) ? MIN_N : sum_w[PW_W-1:0];
      end
    end

    if (frame_tick) begin
      if (tgt_w > cur_w) begin
        dif_w = tgt_w - cur_w;
        if (dif_w > SLEW_W) dif_w = SLEW_W;
        cur_d = cur_q + dif_w[PW_W-1:0];
      end else begin
        dif_w = cur_w - tgt_w;
        if (dif_w > SLEW_W) dif_w = SLEW_W;
        cur_d = cur_q - dif_w[PW_W-1:0];
      end
    end

    busy_d = (tgt_d != cur_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q  <= CTR_N;
      cur_q  <= CTR_N;
      busy_q <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      busy_q <= busy_d;
    end
  end

  assign pw   = cur_q;
  assign busy = busy_q;

endmodule

// File: rtl/arm_servo_ctrl.sv
// Three-axis servo position controller: frame timer, key sync/debounce,
// hold/auto-repeat button FSM and three slew-limited axis ramps.
module arm_servo_ctrl
  import arm_servo_pkg::*;
#(
  parameter int FRAME_TICKS   = DEF_FRAME_TICKS,
  parameter int PW_MIN        = DEF_PW_MIN,
  parameter int PW_MAX        = DEF_PW_MAX,
  parameter int PW_CENTER     = DEF_PW_CENTER,
  parameter int STEP          = DEF_STEP,
  parameter int SLEW          = DEF_SLEW,
  parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
  parameter int REPEAT_FRAMES = DEF_REPEAT_FRAMES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      enable,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            home,
  output logic            frame_tick,
  output logic [PW_W-1:0] pw_x,
  output logic [PW_W-1:0] pw_y,
  output logic [PW_W-1:0] pw_z,
  output logic            busy
);

  localparam int FCW = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
  localparam int CW  = 8;

  localparam logic [FCW-1:0] F_LAST = FCW'(FRAME_TICKS - 1);
  localparam logic [CW-1:0]  H_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0]  R_LAST = CW'(REPEAT_FRAMES - 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           tick_q, tick_d;

  logic [2:0] en_s1_q, en_s2_q;
  // key vectors are {down, up}, 1 = released
  logic [1:0] key_s1_q, key_s2_q;
  logic [1:0] smp0_q, smp0_d;
  logic [1:0] smp1_q, smp1_d;
  logic [1:0] db_q, db_d;
  logic [1:0] agree;

  btn_state_e state_q;
  logic [CW-1:0] cnt_q;
  dir_e       dir_q, ev_dir_q;
  logic       ev_q;

  logic [1:0] pressed;
  logic       valid;
  logic       same;
  dir_e       pdir;

  always_comb begin
    fcnt_d = (fcnt_q == F_LAST) ? '0 : fcnt_q + FCW'(1);
    tick_d = (fcnt_d == F_LAST);

    smp0_d = smp0_q;
    smp1_d = smp1_q;
    if (tick_q) begin
      smp0_d = key_s2_q;
      smp1_d = smp0_q;
    end
    agree = ~(smp0_d ^ smp1_d);
    db_d  = db_q;
    if (tick_q) db_d = (db_q & ~agree) | (smp0_d & agree);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q   <= '0;
      tick_q   <= 1'b0;
      en_s1_q  <= '0;
      en_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      smp0_q   <= '1;
      smp1_q   <= '1;
      db_q     <= '1;
    end else begin
      fcnt_q   <= fcnt_d;
      tick_q   <= tick_d;
      en_s1_q  <= enable;
      en_s2_q  <= en_s1_q;
      key_s1_q <= {btn_down, btn_up};
      key_s2_q <= key_s1_q;
      smp0_q   <= smp0_d;
      smp1_q   <= smp1_d;
      db_q     <= db_d;
    end
  end

  assign pressed = ~db_q;
  assign valid   = ^pressed;
  assign pdir    = pressed[0] ? DIR_UP : DIR_DOWN;
  assign same    = valid && (pdir == dir_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      ev_dir_q <= DIR_UP;
      ev_q     <= 1'b0;
    end else begin
      ev_q <= 1'b0;
      if (tick_q) begin
        unique case (state_q)
          IDLE: begin
            if (valid) begin
              ev_q     <= 1'b1;
              ev_dir_q <= pdir;
              dir_q    <= pdir;
              cnt_q    <= '0;
              state_q  <= HOLD;
            end
          end
          HOLD: begin
            if (!same) begin
              state_q <= IDLE;
            end else if (cnt_q == H_LAST) begin
              ev_q     <= 1'b1;
              ev_dir_q <= dir_q;
              cnt_q    <= '0;
              state_q  <= REPEAT;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          REPEAT: begin
            if (!same) begin
              state_q <= IDLE;
            end else if (cnt_q == R_LAST) begin
              ev_q     <= 1'b1;
              ev_dir_q <= dir_q;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [PW_W-1:0] pw_a [3];
  logic [2:0]      busy_a;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    servo_axis_ramp #(
      .PW_MIN   (PW_MIN),
      .PW_MAX   (PW_MAX),
      .PW_CENTER(PW_CENTER),
      .STEP     (STEP),
      .SLEW     (SLEW)
    ) u_ramp (
      .clk       (clk),
      .rst       (rst),
      .frame_tick(tick_q),
      .ev        (ev_q),
      .dir       (ev_dir_q),
      .axis_en   (en_s2_q[a]),
      .home      (home),
      .pw        (pw_a[a]),
      .busy      (busy_a[a])
    );
  end

  assign frame_tick = tick_q;
  assign pw_x       = pw_a[0];
  assign pw_y       = pw_a[1];
  assign pw_z       = pw_a[2];
  assign busy       = |busy_a;

endmodule

// File: tb/tb_arm_servo_ctrl.sv
// Directed bench for arm_servo_ctrl with short frames and small widths.
// Expected pulse widths are hand-computed frame by frame.
module tb_arm_servo_ctrl;
  import arm_servo_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      enable = 3'b000;
  logic            btn_up = 1'b1;
  logic            btn_down = 1'b1;
  logic            home = 1'b0;
  logic            frame_tick;
  logic [PW_W-1:0] pw_x, pw_y, pw_z;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arm_servo_ctrl #(
    .FRAME_TICKS  (10),
    .PW_MIN       (50),
    .PW_MAX       (100),
    .PW_CENTER    (75),
    .STEP         (5),
    .SLEW         (2),
    .HOLD_FRAMES  (3),
    .REPEAT_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .home      (home),
    .frame_tick(frame_tick),
    .pw_x      (pw_x),
    .pw_y      (pw_y),
    .pw_z      (pw_z),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 20);
    chk("tick_seen", 32'(frame_tick), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_up [8]  = '{75, 75, 75, 77, 79, 80, 82, 84};
  int exp_hm [5]  = '{82, 80, 78, 76, 75};
  int exp_dn [16] = '{75, 75, 75, 73, 71, 70, 68, 66,
                      64, 62, 60, 58, 56, 54, 52, 50};

  initial begin
    int nt;
    int last;
    int e;

    // reset and idle frame timing
    do_reset();
    chk("rst_pw_x", pw_x, 75);
    chk("rst_pw_y", pw_y, 75);
    chk("rst_pw_z", pw_z, 75);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    nt   = 0;
    last = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (frame_tick) begin
        if (nt == 0) chk("tick_first", i, 9);
        else chk("tick_gap", i - last, 10);
        last = i;
        nt++;
      end
    end
    chk("tick_count", nt, 10);
    chk("idle_pw_x", pw_x, 75);
    chk("idle_busy", 32'(busy), 0);

    // single up press on X
    enable = 3'b001;
    to_tick();
    step();
    btn_up = 1'b0;
    to_tick();
    to_tick();
    to_tick();
    btn_up = 1'b1;
    step();
    chk("up_pre_pw_x", pw_x, 75);
    chk("up_pre_busy", 32'(busy), 0);
    step();
    chk("up_busy", 32'(busy), 1);
    to_tick(); step();
    chk("up_pw_x_1", pw_x, 77);
    to_tick(); step();
    chk("up_pw_x_2", pw_x, 79);
    chk("up_busy_2", 32'(busy), 1);
    to_tick(); step();
    chk("up_pw_x_3", pw_x, 80);
    chk("up_busy_done", 32'(busy), 0);
    chk("up_pw_y", pw_y, 75);
    chk("up_pw_z", pw_z, 75);
    to_tick(); to_tick(); to_tick(); step();
    chk("up_pw_x_hold", pw_x, 80);

    // down held on Y and Z with repeat and saturation
    do_reset();
    enable = 3'b110;
    to_tick();
    step();
    btn_down = 1'b0;
    for (int k = 0; k < 30; k++) begin
      to_tick();
      step();
      e = (k < 16) ? exp_dn[k] : 50;
      chk("dn_pw_y", pw_y, e);
      chk("dn_pw_z", pw_z, e);
      chk("dn_pw_x", pw_x, 75);
    end
    btn_down = 1'b1;
    for (int k = 0; k < 4; k++) to_tick();
    chk("dn_busy", 32'(busy), 0);

    // both keys together, then a one-sample glitch
    do_reset();
    enable = 3'b111;
    to_tick();
    step();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    for (int k = 0; k < 10; k++) begin
      to_tick();
      step();
      chk("both_busy", 32'(busy), 0);
      chk("both_pw_y", pw_y, 75);
    end
    btn_up   = 1'b1;
    btn_down = 1'b1;
    for (int k = 0; k < 3; k++) to_tick();
    step();
    btn_up = 1'b0;
    to_tick();
    step();
    btn_up = 1'b1;
    for (int k = 0; k < 5; k++) begin
      to_tick();
      step();
      chk("glitch_busy", 32'(busy), 0);
    end
    chk("glitch_pw_x", pw_x, 75);
    chk("glitch_pw_y", pw_y, 75);
    chk("glitch_pw_z", pw_z, 75);

    // home colliding with an up event while X ramps
    do_reset();
    enable = 3'b001;
    to_tick();
    step();
    btn_up = 1'b0;
    for (int k = 0; k < 8; k++) begin
      to_tick();
      step();
      chk("hm_ramp_pw_x", pw_x, exp_up[k]);
    end
    home = 1'b1;
    step();
    home   = 1'b0;
    enable = 3'b000;
    btn_up = 1'b1;
    chk("hm_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      to_tick();
      step();
      chk("hm_back_pw_x", pw_x, exp_hm[k]);
    end
    chk("hm_busy_done", 32'(busy), 0);
    to_tick(); to_tick(); to_tick(); step();
    chk("hm_pw_x_stay", pw_x, 75);

    // reset mid-ramp during auto-repeat
    do_reset();
    enable = 3'b010;
    to_tick();
    step();
    btn_down = 1'b0;
    for (int k = 0; k < 9; k++) begin
      to_tick();
      step();
      chk("rr_pw_y", pw_y, exp_dn[k]);
    end
    rst = 1'b1;
    step();
    chk("rr_rst_pw_y", pw_y, 75);
    chk("rr_rst_busy", 32'(busy), 0);
    chk("rr_rst_tick", 32'(frame_tick), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_tick();
      step();
      chk("rr_deb_pw_y", pw_y, 75);
      chk("rr_deb_busy", 32'(busy), 0);
    end
    step();
    chk("rr_ev_busy", 32'(busy), 1);
    to_tick();
    step();
    chk("rr_pw_y_1", pw_y, 73);
    btn_down = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_servo_ctrl.md
Name: arm_servo_ctrl

Overview:
Position controller for the three-axis servo arm (X, Y, Z). It turns the shared up/down push-buttons and the per-axis enable switches into slew-limited pulse-width commands, one per axis. It also generates the 20 ms servo frame tick. Its pw_* outputs feed the per-axis PWM generators, which own only the waveform timing.

Parameters:
FRAME_TICKS, 1_000_000, clk cycles per servo frame (20 ms at 50 MHz)
PW_MIN, 50_000, minimum pulse width in clk ticks (1 ms)
PW_MAX, 100_000, maximum pulse width in clk ticks (2 ms)
PW_CENTER, 75_000, reset/home pulse width
STEP, 500, target change per button event
SLEW, 250, maximum change of the output per frame
HOLD_FRAMES, 25, frames a button must be held before auto-repeat starts
REPEAT_FRAMES, 10, frames between auto-repeat events
PW_W, 17, pulse-width bus width; must hold PW_MAX

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
enable  in  3  per-axis move enable [0]=X [1]=Y [2]=Z; asynchronous switches, 2-flop synchronized internally
btn_up  in  1  raw key, active-low, asynchronous; 2-flop synchronized internally
btn_down  in  1  raw key, active-low, asynchronous; 2-flop synchronized internally
home  in  1  synchronous single-cycle pulse; drives all targets to PW_CENTER
frame_tick  out  1  high for one cycle per frame
pw_x  out  PW_W  X pulse width in clk ticks
pw_y  out  PW_W  Y pulse width in clk ticks
pw_z  out  PW_W  Z pulse width in clk ticks
busy  out  1  high while any axis current value differs from its target

Behaviour:
- Reset (rst=1 at a clk edge):
  - frame counter=0, frame_tick=0, busy=0.
  - All targets and current values = PW_CENTER, so pw_*=PW_CENTER.
  - Synchronizer and debounce registers = released (1). FSM = IDLE, repeat counter=0.
- Frame timer: counter runs 0..FRAME_TICKS-1 and wraps. frame_tick=1 only in the cycle where counter==FRAME_TICKS-1.
- Debounce: on each frame_tick, sample each synchronized key into a 2-deep shift register. The debounced level changes only when both samples agree and differ from it, so a key must be stable for 2 consecutive frame samples. Glitches shorter than one frame are never seen.
- Button FSM (single FSM for the key pair). It advances only on frame_tick and emits at most one event per frame.
  - Valid press = exactly one debounced key pressed; dir = up or down.
  - IDLE: on a valid press, emit an event in dir, latch dir, go to HOLD with cnt=0.
  - HOLD: cnt++ each frame. At cnt==HOLD_FRAMES-1, emit an event, go to REPEAT, cnt=0.
  - REPEAT: at cnt==REPEAT_FRAMES-1, emit an event, cnt=0.
  - HOLD or REPEAT: if the debounced key set is no longer exactly {dir} (released, or both keys pressed), go to IDLE with no event.
  - Both keys pressed from IDLE: no event, stay in IDLE.
- Target update, per axis:
  - An event applies to each axis whose synchronized enable bit is 1 in the event cycle.
  - up: target=min(target+STEP, PW_MAX). down: target=max(target-STEP, PW_MIN).
  - Arithmetic uses PW_W+1 bits so intermediate values cannot wrap.
  - A change to enable during HOLD/REPEAT only affects later events.
- home: sets all three targets to PW_CENTER, regardless of enable. If home and an event occur in the same cycle, home wins and the event is dropped.
- Ramp: on each frame_tick, current moves toward the target by min(SLEW, |target-current|) and never overshoots. It uses the target value from before that cycle's update.
- Latency: an event on frame k moves current on frame k+1; the new pw_* is visible the cycle after that frame_tick. pw_* changes only once per frame, so each PWM period sees a stable value.
- busy is registered; it is 1 whenever any current≠target.
- rst asserted mid-ramp or mid-hold aborts everything; values are back to PW_CENTER on the next cycle.

Decomposition:
- Package arm_servo_pkg holds:
  - PW_W and the default PW_MIN, PW_MAX, PW_CENTER, STEP, SLEW constants.
  - The FSM state enum {IDLE, HOLD, REPEAT}.
  - The dir enum {DIR_UP, DIR_DOWN}.
- Sub-module servo_axis_ramp, instantiated 3x. It holds one axis's target and current and implements saturation, home and slew. Inputs: clk, rst, frame_tick, event, dir, axis_en, home. Outputs: pw, busy.

Test Plan:
Simulation parameters: FRAME_TICKS=10, PW_MIN=50, PW_MAX=100, PW_CENTER=75, STEP=5, SLEW=2, HOLD_FRAMES=3, REPEAT_FRAMES=2.
- Reset then idle 100 cycles -> pw_x/y/z=75, busy=0, frame_tick exactly every 10th cycle.
- enable=001, btn_up low for 3 frames then released -> X target 80; pw_x steps 77, 79, 80 on consecutive frames; pw_y=pw_z=75; busy falls after 80 is reached.
- enable=110, btn_down held for 30 frames -> events at press, at +3 frames, then every 2 frames; pw_y/pw_z ramp down and saturate at 50, never below; pw_x=75.
- Both keys held together for 10 frames; also a 1-frame glitch on btn_up -> no events, pw_* unchanged, busy=0.
- home pulse while X is ramping from 75 toward 90, coinciding with an up event -> target=75, the event is dropped, pw_x ramps back to 75 by at most 2 per frame.
- rst pulse mid-ramp during REPEAT -> the next cycle shows pw_*=75, busy=0, FSM in IDLE; a held key must pass debounce again before any new event.
